// File: rtl/fp16_pkg.sv
// Shared constants and the controller state encoding for the FP16 sequential divider.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int BIAS   = 15;
  localparam int Q_W    = MANT_W + 2;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/fp16_mant_divider.sv
// Radix-2 restoring divider for the 11-bit significands: one quotient bit per clock, MSB first.
module fp16_mant_divider
  import fp16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MANT_W:0]  mant_a,
  input  logic [MANT_W:0]  mant_b,
  output logic             last_step,
  output logic [Q_W-1:0]   quotient_next
);

  logic [Q_W-1:0] rem;
  logic [Q_W-1:0] diff;
  logic [Q_W-1:0] quo;
  logic [MANT_W:0] divisor;
  logic [3:0]     cnt;
  logic           busy;
  logic           ge;

  // quotient_next already contains the bit decided this cycle, so the top can
  // capture the full quotient on the same edge as the final step.
  always_comb begin
    ge            = (rem >= {1'b0, divisor});
    diff          = ge ? (rem - {1'b0, divisor}) : rem;
    quotient_next = quo | (Q_W'(ge) << cnt);
    last_step     = busy && (cnt == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      rem     <= {1'b0, mant_a};
      divisor <= mant_b;
      quo     <= '0;
      cnt     <= 4'(Q_W - 1);
      busy    <= 1'b1;
    end else if (busy) begin
      // The partial remainder is always below the divisor, so its MSB is zero here.
      rem <= {diff[Q_W-2:0], 1'b0};
      quo <= quotient_next;
      if (cnt == 4'd0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/fp16_seq_divider.sv
// Sequential binary16 divider: FSM, zero-operand decode, exponent/normalise/clamp and output register.
module fp16_seq_divider
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  state_t state, next_state;

  logic              sign_in;
  logic              zero_a;
  logic              zero_b;
  logic              special;
  logic [15:0]       special_val;
  logic              accept;
  logic              start;
  logic              last_step;
  logic [Q_W-1:0]    q_next;
  logic              sign_q;
  logic signed [6:0] te_q;
  logic signed [6:0] e;
  logic [MANT_W-1:0] mant;
  logic [15:0]       result;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign start     = accept && !special;

  // Zero means both exponent and mantissa clear, so -0 is treated like +0.
  always_comb begin
    sign_in = a[15] ^ b[15];
    zero_a  = (a[14:0] == 15'd0);
    zero_b  = (b[14:0] == 15'd0);
    special = zero_a || zero_b;
    if (zero_a && zero_b) begin
      special_val = FP16_QNAN;
    end else if (zero_b) begin
      special_val = {sign_in, 5'h1F, 10'h000};
    end else begin
      special_val = 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = special ? DONE : DIVIDE;
      DIVIDE:  if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  fp16_mant_divider u_mant (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mant_a       ({1'b1, a[MANT_W-1:0]}),
    .mant_b       ({1'b1, b[MANT_W-1:0]}),
    .last_step    (last_step),
    .quotient_next(q_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      te_q   <= '0;
    end else if (accept) begin
      sign_q <= sign_in;
      te_q   <= 7'({2'b00, a[14:10]}) - 7'({2'b00, b[14:10]}) + 7'(BIAS);
    end
  end

  // A quotient without bit 11 set needs one extra left shift, costing one exponent step.
  always_comb begin
    e    = q_next[Q_W-1] ? te_q : (te_q - 7'sd1);
    mant = q_next[Q_W-1] ? q_next[MANT_W:1] : q_next[MANT_W-1:0];
    if (e >= 7'sd31) begin
      result = {sign_q, 5'h1F, 10'h000};
    end else if (e <= 7'sd0) begin
      result = 16'h0000;
    end else begin
      result = {sign_q, e[4:0], mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'h0000;
    end else if (accept && special) begin
      out <= special_val;
    end else if (state == DIVIDE && last_step) begin
      out <= result;
    end
  end

endmodule

// File: tb/tb_fp16_seq_divider.sv
// Self-checking bench for fp16_seq_divider: directed steps, a scoreboard queue and a small reference model.
module tb_fp16_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accepts = 0;
  int accept_cyc = 0;
  logic [15:0] sb_q[$];

  fp16_seq_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  always #5 clk = ~clk;

  // Edge counter plus a record of which edge accepted the latest operands.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      accepts    <= accepts + 1;
      accept_cyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
    logic s;
    int unsigned ma, mb, q;
    int e;
    logic [9:0] m;
    s = x[15] ^ y[15];
    if (x[14:0] == 15'd0 && y[14:0] == 15'd0) return 16'h7E00;
    if (y[14:0] == 15'd0) return {s, 15'h7C00};
    if (x[14:0] == 15'd0) return 16'h0000;
    ma = 1024 + int'(x[9:0]);
    mb = 1024 + int'(y[9:0]);
    q  = (ma * 2048) / mb;
    e  = int'(x[14:10]) - int'(y[14:10]) + 15;
    if (q >= 2048) begin
      m = 10'(q >> 1);
    end else begin
      m = 10'(q);
      e = e - 1;
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0) return 16'h0000;
    return {s, 5'(e), m};
  endfunction

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp);
    int n;
    sb_q.push_back(exp);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_wait", 16'(in_ready), 16'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // lat_kind: 0 = full division (12 edges), 1 = special case (at most 1), 2 = not checked.
  task automatic waitResult(input string tag, input int lat_kind);
    int n;
    int lat;
    logic [15:0] exp;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 16'(out_valid), 16'd1);
    lat = cyc - accept_cyc;
    if (lat_kind == 0) checkOutput({tag, "_latency"}, 16'(lat), 16'd12);
    else if (lat_kind == 1) checkOutput({tag, "_latency_le1"}, 16'(lat <= 1), 16'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    checkOutput(tag, out, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_cleared"}, 16'(out_valid), 16'd0);
    checkOutput({tag, "_in_ready_back"}, 16'(in_ready), 16'd1);
    checkOutput({tag, "_out_held"}, out, exp);
  endtask

  initial begin
    logic [15:0] x, y;
    int acc0;
    int n;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    #1;
    checkOutput("reset_out", out, 16'h0000);
    checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h4000, 16'h3C00, 16'h4000);
    waitResult("two_div_one", 0);
    applyStimulus(16'h3C00, 16'h4200, 16'h3555);
    waitResult("one_div_three", 0);
    applyStimulus(16'hC500, 16'h4000, 16'hC100);
    waitResult("neg5_div_two", 0);

    applyStimulus(16'h3C00, 16'h0000, 16'h7C00);
    waitResult("div_by_zero", 1);
    applyStimulus(16'h0000, 16'h0000, 16'h7E00);
    waitResult("zero_div_zero", 1);
    applyStimulus(16'h0000, 16'h4000, 16'h0000);
    waitResult("zero_div_two", 1);
    applyStimulus(16'h8000, 16'h4000, 16'h0000);
    waitResult("negzero_div_two", 1);

    applyStimulus(16'h7BFF, 16'h0400, 16'h7C00);
    waitResult("overflow", 0);
    applyStimulus(16'h0400, 16'h7BFF, 16'h0000);
    waitResult("underflow", 0);

    for (int i = 0; i < 6; i++) begin
      x = {1'($urandom), 5'($urandom_range(5, 25)), 10'($urandom)};
      y = {1'($urandom), 5'($urandom_range(5, 25)), 10'($urandom)};
      applyStimulus(x, y, model(x, y));
      waitResult($sformatf("random%0d", i), 0);
    end

    // Back-pressure: result must stay put and no new operands may slip in.
    applyStimulus(16'h4000, 16'h3C00, 16'h4000);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    a = 16'h4200;
    b = 16'h3C00;
    in_valid = 1'b1;
    acc0 = accepts;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_out_stable", out, 16'h4000);
      checkOutput("bp_in_ready", 16'(in_ready), 16'd0);
      checkOutput("bp_out_valid", 16'(out_valid), 16'd1);
    end
    in_valid = 1'b0;
    checkOutput("bp_no_accept", 16'(accepts - acc0), 16'd0);
    waitResult("bp_result", 2);

    // Reset mid-division at cnt==5 abandons the operation.
    applyStimulus(16'h3C00, 16'h4200, 16'h3555);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_mid_in_ready", 16'(in_ready), 16'd1);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("rst_no_result", 16'(out_valid), 16'd0);
    applyStimulus(16'hC500, 16'h4000, 16'hC100);
    waitResult("after_reset", 0);

    checkOutput("scoreboard_empty", 16'(sb_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
